// File: rtl/riscv_rf_wb_scheduler.sv
// Write-back scheduler: arbitrates NUM_REQ requesters onto two register-file write ports
// and tracks pending writes per register. Define RF_WB_FIXED_PRIO_EN for fixed priority.
module riscv_rf_wb_scheduler #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
  output logic                                 we_a_o,
  output logic [ADDR_WIDTH-1:0]                waddr_a_o,
  output logic [DATA_WIDTH-1:0]                wdata_a_o,
  output logic                                 we_b_o,
  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [DATA_WIDTH-1:0]                wdata_b_o,
  input  logic                                 alloc_valid_i,
  input  logic [ADDR_WIDTH-1:0]                alloc_addr_i,
  input  logic                                 flush_i,
  input  logic [ADDR_WIDTH-1:0]                chk_addr_a_i,
  input  logic [ADDR_WIDTH-1:0]                chk_addr_b_i,
  input  logic [ADDR_WIDTH-1:0]                chk_addr_c_i,
  output logic                                 busy_a_o,
  output logic                                 busy_b_o,
  output logic                                 busy_c_o
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
  localparam int unsigned RR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [RR_W-1:0]       start_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic                  grant_a_s;
  logic                  grant_b_s;
  logic [RR_W-1:0]       idx_a_s;
  logic [RR_W-1:0]       idx_b_s;
  logic [NUM_REGS-1:0]   clr_mask_s;
  logic [NUM_REGS-1:0]   set_mask_s;
  logic [NUM_REGS-1:0]   pending_d;
  logic [NUM_REGS-1:0]   pending_q;
  logic                  we_a_d, we_a_q, we_b_d, we_b_q;
  logic [ADDR_WIDTH-1:0] waddr_a_d, waddr_a_q, waddr_b_d, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_d, wdata_a_q, wdata_b_d, wdata_b_q;

  // Rotating scan: x0 requests are acked without a port; port B needs a different address than A.
  always_comb begin : arb_comb
    int              pos;
    logic [RR_W-1:0] idx;
    ready_s   = '0;
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    idx_a_s   = '0;
    idx_b_s   = '0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      pos = int'(start_s) + k;
      if (pos >= int'(NUM_REQ)) begin
        pos = pos - int'(NUM_REQ);
      end else begin
        pos = pos + 0;
      end
      idx = RR_W'(pos);
      if (!req_valid_i[idx]) begin
        ready_s[idx] = 1'b0;
      end else if (req_addr_i[idx] == '0) begin
        ready_s[idx] = 1'b1;
      end else if (!grant_a_s) begin
        grant_a_s    = 1'b1;
        idx_a_s      = idx;
        ready_s[idx] = 1'b1;
      end else if (!grant_b_s && (req_addr_i[idx] != req_addr_i[idx_a_s])) begin
        grant_b_s    = 1'b1;
        idx_b_s      = idx;
        ready_s[idx] = 1'b1;
      end else begin
        ready_s[idx] = 1'b0;
      end
    end
  end

  assign req_ready_o = ready_s & {NUM_REQ{rst_n}};

`ifdef RF_WB_FIXED_PRIO_EN
  assign start_s = '0;
`else
  logic [RR_W-1:0] rr_d, rr_q, last_s;

  // Pointer moves past the last port grant; x0 acks and idle cycles leave it alone.
  always_comb begin
    last_s = grant_b_s ? idx_b_s : idx_a_s;
    if (!grant_a_s) begin
      rr_d = rr_q;
    end else if (last_s == RR_W'(NUM_REQ - 1)) begin
      rr_d = '0;
    end else begin
      rr_d = last_s + RR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign start_s = rr_q;
`endif

  // Next-cycle port contents; idle ports drive zero.
  always_comb begin
    we_a_d    = grant_a_s;
    waddr_a_d = grant_a_s ? req_addr_i[idx_a_s] : '0;
    wdata_a_d = grant_a_s ? req_data_i[idx_a_s] : '0;
    we_b_d    = grant_b_s;
    waddr_b_d = grant_b_s ? req_addr_i[idx_b_s] : '0;
    wdata_b_d = grant_b_s ? req_data_i[idx_b_s] : '0;
  end

  // Scoreboard update: grants clear, allocs set (set wins), flush clears everything.
  always_comb begin
    clr_mask_s = '0;
    set_mask_s = '0;
    clr_mask_s[req_addr_i[idx_a_s]] = clr_mask_s[req_addr_i[idx_a_s]] | grant_a_s;
    clr_mask_s[req_addr_i[idx_b_s]] = clr_mask_s[req_addr_i[idx_b_s]] | grant_b_s;
    set_mask_s[alloc_addr_i]        = alloc_valid_i;
    pending_d    = flush_i ? '0 : ((pending_q & ~clr_mask_s) | set_mask_s);
    pending_d[0] = 1'b0;
  end

  // Port and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      pending_q <= '0;
    end else begin
      we_a_q    <= we_a_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      we_b_q    <= we_b_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
      pending_q <= pending_d;
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;

  assign busy_a_o = pending_q[chk_addr_a_i];
  assign busy_b_o = pending_q[chk_addr_b_i];
  assign busy_c_o = pending_q[chk_addr_c_i];

endmodule

// File: tb/tb_riscv_rf_wb_scheduler.sv
// Table-driven bench for riscv_rf_wb_scheduler: ready/busy checked in-cycle, port writes via a
// scoreboard queue one cycle later, plus hand-written reset sequences.
module tb_riscv_rf_wb_scheduler;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0][5:0]  req_addr;
  logic [2:0][31:0] req_data;
  logic             we_a, we_b;
  logic [5:0]       waddr_a, waddr_b;
  logic [31:0]      wdata_a, wdata_b;
  logic             alloc_valid;
  logic [5:0]       alloc_addr;
  logic             flush;
  logic [5:0]       chk_a, chk_b, chk_c;
  logic             busy_a, busy_b, busy_c;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_rf_wb_scheduler #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_REQ(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .we_a_o(we_a), .waddr_a_o(waddr_a), .wdata_a_o(wdata_a),
    .we_b_o(we_b), .waddr_b_o(waddr_b), .wdata_b_o(wdata_b),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr), .flush_i(flush),
    .chk_addr_a_i(chk_a), .chk_addr_b_i(chk_b), .chk_addr_c_i(chk_c),
    .busy_a_o(busy_a), .busy_b_o(busy_b), .busy_c_o(busy_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [17:0] addr;    // {req2, req1, req0}
    logic [95:0] data;    // {req2, req1, req0}
    logic        alloc;
    logic [5:0]  alloc_a;
    logic        flush;
    logic [17:0] chk;     // {c, b, a}
    logic [2:0]  rdy;
    logic [2:0]  busy;    // {c, b, a}
    logic [38:0] pa;      // {we, waddr, wdata} expected next cycle
    logic [38:0] pb;
  } vec_t;

  typedef struct {
    logic [38:0] pa;
    logic [38:0] pb;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  localparam logic [38:0] NOP = 39'd0;
  localparam logic [17:0] Z18 = 18'd0;
  localparam logic [95:0] Z96 = 96'd0;

  function automatic vec_t mk(input logic [2:0] valid, input logic [17:0] addr, input logic [95:0] data,
                              input logic alloc, input logic [5:0] alloc_a, input logic fl,
                              input logic [17:0] chk, input logic [2:0] rdy, input logic [2:0] busy,
                              input logic [38:0] pa, input logic [38:0] pb);
    vec_t v;
    v.valid = valid; v.addr = addr; v.data = data; v.alloc = alloc; v.alloc_a = alloc_a;
    v.flush = fl; v.chk = chk; v.rdy = rdy; v.busy = busy; v.pa = pa; v.pb = pb;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid   = v.valid;
    req_addr    = v.addr;
    req_data    = v.data;
    alloc_valid = v.alloc;
    alloc_addr  = v.alloc_a;
    flush       = v.flush;
    chk_a       = v.chk[5:0];
    chk_b       = v.chk[11:6];
    chk_c       = v.chk[17:12];
  endtask

  task automatic pop_check(input int id);
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("port_a[%0d]", id), {we_a, waddr_a, wdata_a}, e.pa);
      check($sformatf("port_b[%0d]", id), {we_b, waddr_b, wdata_b}, e.pb);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    pop_check(id);
    drive(v);
    #1;
    check($sformatf("ready[%0d]", id), req_ready, v.rdy);
    check($sformatf("busy[%0d]", id), {busy_c, busy_b, busy_a}, v.busy);
    e.pa = v.pa;
    e.pb = v.pb;
    exp_q.push_back(e);
  endtask

  function automatic logic [95:0] all_outs();
    return {req_ready, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, busy_c, busy_b, busy_a};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vec_t idle;
    idle = mk(3'b000, Z18, Z96, 1'b0, 6'd0, 1'b0, Z18, 3'b000, 3'b000, NOP, NOP);

    // Table: rr pointer starts at 0 after reset.
    tbl.push_back(idle);
    tbl.push_back(mk(3'b001, {6'd0, 6'd0, 6'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, 6'd0, 1'b0, Z18,
                     3'b001, 3'b000, {1'b1, 6'd5, 32'hDEADBEEF}, NOP));                  // single write, rr->1
    tbl.push_back(mk(3'b010, Z18, Z96, 1'b0, 6'd0, 1'b0, Z18, 3'b010, 3'b000, NOP, NOP));   // x0 ack, rr stays 1
    tbl.push_back(mk(3'b110, {6'd13, 6'd12, 6'd0}, {32'h13, 32'h12, 32'h0}, 1'b0, 6'd0, 1'b0, Z18,
                     3'b110, 3'b000, {1'b1, 6'd12, 32'h12}, {1'b1, 6'd13, 32'h13}));        // rr=1 proves x0 kept it; rr->0
    tbl.push_back(mk(3'b111, {6'd9, 6'd7, 6'd3}, {32'h99, 32'h77, 32'h33}, 1'b0, 6'd0, 1'b0, Z18,
                     3'b011, 3'b000, {1'b1, 6'd3, 32'h33}, {1'b1, 6'd7, 32'h77}));          // dual grant, rr->2
    tbl.push_back(mk(3'b100, {6'd9, 6'd0, 6'd0}, {32'h99, 64'd0}, 1'b0, 6'd0, 1'b0, Z18,
                     3'b100, 3'b000, {1'b1, 6'd9, 32'h99}, NOP));                           // req2 next, rr->0
    tbl.push_back(mk(3'b011, {6'd0, 6'd4, 6'd4}, {32'h0, 32'h42, 32'h41}, 1'b0, 6'd0, 1'b0, Z18,
                     3'b001, 3'b000, {1'b1, 6'd4, 32'h41}, NOP));                           // conflict on 4, rr->1
    tbl.push_back(mk(3'b010, {6'd0, 6'd4, 6'd0}, {32'h0, 32'h42, 32'h0}, 1'b0, 6'd0, 1'b0, Z18,
                     3'b010, 3'b000, {1'b1, 6'd4, 32'h42}, NOP));                           // second write to 4, rr->2
    tbl.push_back(mk(3'b000, Z18, Z96, 1'b1, 6'd10, 1'b0, {12'd0, 6'd10}, 3'b000, 3'b000, NOP, NOP));
    tbl.push_back(mk(3'b000, Z18, Z96, 1'b0, 6'd0, 1'b0, {12'd0, 6'd10}, 3'b000, 3'b001, NOP, NOP));
    tbl.push_back(mk(3'b000, Z18, Z96, 1'b0, 6'd0, 1'b0, {12'd0, 6'd10}, 3'b000, 3'b001, NOP, NOP));
    tbl.push_back(mk(3'b001, {12'd0, 6'd10}, {64'd0, 32'hA0}, 1'b0, 6'd0, 1'b0, {12'd0, 6'd10},
                     3'b001, 3'b001, {1'b1, 6'd10, 32'hA0}, NOP));                          // grant 10, rr->1
    tbl.push_back(mk(3'b000, Z18, Z96, 1'b0, 6'd0, 1'b0, {12'd0, 6'd10}, 3'b000, 3'b000, NOP, NOP));
    tbl.push_back(mk(3'b010, {6'd0, 6'd10, 6'd0}, {32'h0, 32'hA1, 32'h0}, 1'b1, 6'd10, 1'b0, {12'd0, 6'd10},
                     3'b010, 3'b000, {1'b1, 6'd10, 32'hA1}, NOP));                          // alloc+grant same reg
    tbl.push_back(mk(3'b000, Z18, Z96, 1'b1, 6'd33, 1'b0, {6'd0, 6'd33, 6'd10}, 3'b000, 3'b001, NOP, NOP));
    tbl.push_back(mk(3'b000, Z18, Z96, 1'b1, 6'd20, 1'b1, {6'd20, 6'd33, 6'd10}, 3'b000, 3'b011, NOP, NOP));
    tbl.push_back(mk(3'b000, Z18, Z96, 1'b0, 6'd0, 1'b0, {6'd20, 6'd33, 6'd10}, 3'b000, 3'b000, NOP, NOP));

    // Reset state.
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 96'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end
    @(negedge clk);
    pop_check(100);

    // Reset in the middle of a grant: registered write is dropped, pointer and scoreboard cleared.
    apply(mk(3'b001, {12'd0, 6'd6}, {64'd0, 32'h66}, 1'b1, 6'd15, 1'b0, {12'd0, 6'd15},
             3'b001, 3'b000, {1'b1, 6'd6, 32'h66}, NOP), 200);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pre_reset_port_a", {we_a, waddr_a, wdata_a}, e.pa);
    check("pre_reset_busy15", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", all_outs(), 96'd0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    #1;
    check("post_reset_busy15", busy_a, 1'b0);

    // Pointer back at 0: req0 takes A, req1 takes B.
    apply(mk(3'b011, {6'd0, 6'd2, 6'd1}, {32'h0, 32'h22, 32'h11}, 1'b0, 6'd0, 1'b0, Z18,
             3'b011, 3'b000, {1'b1, 6'd1, 32'h11}, {1'b1, 6'd2, 32'h22}), 201);
    apply(idle, 202);
    @(negedge clk);
    pop_check(203);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_rf_wb_scheduler.md
Name: riscv_rf_wb_scheduler

Overview:
- Write-back scheduler in front of the integer/FP register file, which has two write ports (A, B) and three read ports.
- Arbitrates up to NUM_REQ write-back requesters (ALU/EX, LSU, long-latency MULT/DIV/FPU) onto the two write ports, at most two grants per cycle, round-robin.
- Keeps a pending-write scoreboard per register so the ID stage can stall operand reads whose producer has not yet written back.

Parameters:
- ADDR_WIDTH, 6, register address width; bit 5 selects the FP bank; NUM_REGS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, write data width.
- NUM_REQ, 3, number of write-back requesters; legal range 2..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  requester i has a write pending
- req_ready_o  out  NUM_REQ  requester i granted this cycle
- req_addr_i  in  NUM_REQ x ADDR_WIDTH  destination register per requester
- req_data_i  in  NUM_REQ x DATA_WIDTH  write data per requester
- we_a_o / waddr_a_o / wdata_a_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port A
- we_b_o / waddr_b_o / wdata_b_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port B
- alloc_valid_i  in  1  an instruction with a destination register issues this cycle
- alloc_addr_i  in  ADDR_WIDTH  destination register of the issuing instruction
- flush_i  in  1  pipeline flush; clears the scoreboard
- chk_addr_a_i / chk_addr_b_i / chk_addr_c_i  in  ADDR_WIDTH each  operand addresses to check
- busy_a_o / busy_b_o / busy_c_o  out  1 each  operand has a pending write

Behaviour:
- Reset: all outputs 0, all pending bits 0, rr_q = 0.
- Handshake:
  - A transfer occurs on req_valid_i[i] & req_ready_o[i].
  - The requester holds valid, addr and data stable until ready.
  - req_ready_o is combinational from valid, addr and rr_q; valid must not depend on ready.
- Arbitration (combinational, each cycle):
  - Scan indices rr_q, rr_q+1, … mod NUM_REQ.
  - The first valid requester with a nonzero address takes port A.
  - The next valid requester with a nonzero address different from port A's address takes port B.
  - Same-address conflict: the second requester is not granted and waits.
- Address 0 (x0):
  - A valid request with address 0 is acked (ready=1) in the same cycle.
  - It consumes no write port and never drives we.
- Output timing:
  - Port outputs are registered: a grant in cycle N gives we/waddr/wdata in cycle N+1, held for exactly 1 cycle.
  - With only one grant, port A is used and we_b_o = 0.
- Pointer update:
  - rr_q <= (index of the last port grant) + 1 mod NUM_REQ.
  - rr_q is unchanged if nothing was granted. x0 acks do not move rr_q.
- Scoreboard pending_q[NUM_REQS]:
  - Set on alloc_valid_i with alloc_addr_i != 0.
  - Cleared on the cycle the write is granted (cycle N).
  - Alloc and grant to the same address in the same cycle: the set wins.
  - pending_q[0] is constant 0.
- busy_x_o = pending_q[chk_addr_x_i], combinational. There is no bypass: a register cleared in cycle N reads busy=0 from cycle N+1, aligned with the register-file write.
- flush_i: clears all pending_q at the next edge; an alloc in the same cycle is ignored. In-flight port writes (registered) still complete.
- Reset mid-operation: registered port writes are dropped; the scoreboard and rr_q return to reset values.

Optional Feature:
- Macro RF_WB_FIXED_PRIO_EN.
- Defined: the scan always starts at index 0 (lowest index has highest priority); rr_q is removed.
- Undefined: round-robin as described above.

Test Plan:
- Single write: req0 valid, addr=5, data=0xDEADBEEF, rr_q=0 → ready0=1 in cycle N; in cycle N+1, we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF, we_b_o=0.
- Dual grant: req0 addr=3, req1 addr=7, req2 addr=9, all valid, rr_q=0 → grant 0 to port A and 1 to port B; rr_q=2; next cycle req2 is granted to port A.
- Address conflict: req0 and req1 both addr=4, rr_q=0 → only req0 granted; req1 granted the next cycle; two consecutive port-A writes to 4, second data last.
- x0 write: req1 valid, addr=0 → ready1=1 in the same cycle, we_a_o=0 and we_b_o=0 next cycle, rr_q unchanged.
- Scoreboard: alloc addr=10 in cycle 0 → busy_a_o=1 for chk_addr_a_i=10 from cycle 1; write to 10 granted in cycle 3 → busy=0 from cycle 4; alloc and grant of addr=10 in the same cycle → busy stays 1.
- Flush/reset: pending on 10 and 33, flush_i=1 → both busy=0 next cycle; rst_n low mid-grant → we_a_o=0 and all outputs 0 while rst_n is low.
